// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction fetch front end with PC-tagged FIFO and redirect flush
module fetch_queue #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter int PC_STEP     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      entry,
  output logic                       ic_read,
  output logic [ADDR_WIDTH-1:0]      ic_addr,
  input  logic                       ic_busy,
  input  logic [INSTR_WIDTH-1:0]     ic_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc,
  output logic                       out_valid,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]         FULL = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   fetch_pc;
  logic [ADDR_WIDTH-1:0]   drain_addr;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count_q;
  logic [ADDR_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0]  instr_mem [DEPTH];
  logic                    completing;
  logic                    push;
  logic                    pop;

  // Request decode looks only at registered state so the cache never sees a
  // combinational path from its own busy or from decode's ready.
  assign ic_read    = ((state == FETCH) && (count_q < FULL)) || (state == DRAIN);
  assign ic_addr    = (state == DRAIN) ? drain_addr : fetch_pc;
  assign completing = ic_read && !ic_busy;
  assign push       = (state == FETCH) && completing && !redirect_valid;
  assign pop        = out_valid && out_ready && !redirect_valid;

  assign out_valid  = (count_q != '0);
  assign out_pc     = pc_mem[rd_ptr];
  assign out_instr  = instr_mem[rd_ptr];
  assign count      = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= ic_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= entry;
      drain_addr <= entry;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
    end else if (redirect_valid) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      fetch_pc <= redirect_pc;
      case (state)
        FETCH: begin
          // A read still waiting on the cache must be seen through at its
          // original address before the new stream can start.
          if (ic_read && ic_busy) begin
            state      <= DRAIN;
            drain_addr <= fetch_pc;
          end else begin
            state <= FETCH;
          end
        end
        DRAIN:   state <= DRAIN;
        default: state <= FETCH;
      endcase
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + STEP;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      case (state)
        IDLE:    state <= FETCH;
        DRAIN:   if (!ic_busy) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end that replaces the free-running `pc <= pc + 4` loop in `top`. It owns the fetch PC and issues sequential reads to the cache's instruction port using the existing read/busy contract. Returned instructions are buffered in a DEPTH-entry FIFO tagged with their PC and handed to decode over a valid/ready handshake. Control-flow redirects flush the FIFO and safely discard any in-flight cache read.

## Interface
- ADDR_WIDTH, 64: fetch PC / cache address width.
- INSTR_WIDTH, 32: instruction width.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- PC_STEP, 4: PC increment per fetched instruction.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- entry  in  ADDR_WIDTH  fetch PC loaded on reset.
- ic_read  out  1  read request to cache (instruction_read).
- ic_addr  out  ADDR_WIDTH  request address (instruction_address).
- ic_busy  in  1  cache busy; a response completes in any cycle with ic_read=1 and ic_busy=0.
- ic_data  in  INSTR_WIDTH  instruction for ic_addr; valid only in a completing cycle.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_WIDTH  new fetch PC.
- out_valid  out  1  FIFO head valid.
- out_pc  out  ADDR_WIDTH  PC of head entry.
- out_instr  out  INSTR_WIDTH  instruction of head entry.
- out_ready  in  1  decode accepts head.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- States: IDLE (reset only), FETCH, DRAIN.
- Reset: fetch_pc=entry, state=IDLE, FIFO empty, count=0, out_valid=0, ic_read=0, ic_addr=entry. Leaving reset: IDLE→FETCH unconditionally next cycle.
- ic_read = (FETCH && count<DEPTH) || DRAIN; decoded from registered state only, never from ic_busy or out_ready.
- ic_addr = fetch_pc in FETCH; the held dropped address in DRAIN. ic_addr does not change while ic_read=1 and ic_busy=1, except through a DRAIN entry that holds it.
- FETCH completion (ic_read=1, ic_busy=0, no redirect): push {fetch_pc, ic_data}; fetch_pc += PC_STEP modulo 2^ADDR_WIDTH.
- Pop when out_valid && out_ready. Push and pop in the same cycle leaves count unchanged. No push can occur at count=DEPTH because ic_read=0.
- Redirect has priority over push and pop. FIFO is emptied, count=0, fetch_pc=redirect_pc. Next state:
  - In FETCH with ic_read=1 and ic_busy=1: DRAIN, with ic_addr held at the old address.
  - In FETCH otherwise, including a same-cycle completion whose data is discarded: FETCH.
  - In DRAIN: stay DRAIN; fetch_pc takes the newest redirect_pc.
- DRAIN: no pushes. When ic_busy=0, the response is discarded and the state goes to FETCH. Fetch then resumes at fetch_pc on the following cycle.
- FIFO read/write pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Cache hit with ic_busy=0: one instruction per cycle sustained while out_ready=1.
- Latency from a completing cycle to out_valid=1 is 1 cycle (registered FIFO, no bypass).
- Reset deasserts at edge N: ic_read=1 from cycle N+1.
- A redirect in cycle R: out_valid=0 in cycle R+1; the first new request is in R+1 (FETCH) or in the cycle after DRAIN exits.
- Reset mid-operation, including in DRAIN with ic_busy=1: returns to reset values next edge. The outstanding cache read is abandoned; the cache is reset by the same signal.
- out_pc/out_instr are don't-care when out_valid=0.

## Test plan
- Zero-wait cache, entry=0x1000, out_ready=1: out_pc sequence 0x1000, 0x1004, 0x1008…, one per cycle, first out_valid two cycles after reset falls.
- out_ready=0, DEPTH=4: count reaches 4, ic_read drops to 0, fetch_pc=0x1010. Asserting out_ready pops 0x1000 first and refetch resumes at 0x1010 with no gap or duplicate.
- Cache busy 3 cycles per read, redirect to 0x2000 during busy: DRAIN entered, ic_addr held until busy falls, that data is never output, next out_pc=0x2000.
- Redirect to 0x3000 in the same cycle as a completion with simultaneous pop at count=2: completion discarded, count=0, next out_pc=0x3000.
- entry=0xFFFF_FFFF_FFFF_FFF8: out_pc sequence …FFF8, …FFFC, 0x0, 0x4.
- Reset asserted in DRAIN with entry=0x5000: all outputs at reset values next cycle, first output afterwards 0x5000.
